// File: rtl/player_step_pkg.sv
// Shared types for the player step controller: headings, FSM states, cell
// positions and the bit positions of the grid exception word.
package player_step_pkg;

  localparam int POS_W = 6;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } heading_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    STEP1,
    STEP2,
    HALT
  } state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  localparam int EXC_ANY   = 0;
  localparam int EXC_WIN1  = 1;
  localparam int EXC_WIN   = 2;
  localparam int EXC_CRASH = 4;

  // Reversing straight into your own trail is never a legal turn.
  function automatic heading_t opposite(input heading_t h);
    return heading_t'(h ^ 2'b10);
  endfunction

endpackage

// File: rtl/heading_reg.sv
// Per-player heading register: accepts a single-button turn unless it reverses
// the current heading, and computes the wrapped next cell along that heading.
module heading_reg
  import player_step_pkg::*;
#(
  parameter heading_t INIT_HEAD = RIGHT,
  parameter int       GRID_W    = 64,
  parameter int       GRID_H    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic [3:0] btn,
  input  pos_t       pos,
  output pos_t       nxt
);

  localparam logic [POS_W-1:0] X_MASK = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_MASK = POS_W'(GRID_H - 1);

  heading_t head_q, head_d, btn_head;

  // Anything other than exactly one pressed button maps back to the current heading.
  always_comb begin
    case (btn)
      4'b0001: btn_head = UP;
      4'b0010: btn_head = RIGHT;
      4'b0100: btn_head = DOWN;
      4'b1000: btn_head = LEFT;
      default: btn_head = head_q;
    endcase
    head_d = head_q;
    if (!hold && (btn_head != opposite(head_q))) head_d = btn_head;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) head_q <= INIT_HEAD;
    else        head_q <= head_d;
  end

  always_comb begin
    nxt = pos;
    case (head_q)
      UP:      nxt.y = (pos.y - POS_W'(1)) & Y_MASK;
      DOWN:    nxt.y = (pos.y + POS_W'(1)) & Y_MASK;
      LEFT:    nxt.x = (pos.x - POS_W'(1)) & X_MASK;
      RIGHT:   nxt.x = (pos.x + POS_W'(1)) & X_MASK;
      default: nxt = pos;
    endcase
  end

endmodule

// File: rtl/player_step_ctrl.sv
// Paces both players with a tick divider, issues one grid step per player per
// tick, and freezes on the first grid exception.
module player_step_ctrl
  import player_step_pkg::*;
#(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 64,
  parameter int TICK_DIV = 500000,
  parameter int P1_X0    = 8,
  parameter int P1_Y0    = 32,
  parameter int P2_X0    = 55,
  parameter int P2_Y0    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  btn_p1,
  input  logic [3:0]  btn_p2,
  input  logic [31:0] exc_in,
  output logic [31:0] play_x,
  output logic [31:0] play_y,
  output logic        play_num,
  output logic        super_enable,
  output logic        running,
  output logic        halted,
  output logic [4:0]  result,
  output logic [15:0] step_count
);

  localparam int             CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam pos_t           P1_INIT  = '{x: POS_W'(P1_X0), y: POS_W'(P1_Y0)};
  localparam pos_t           P2_INIT  = '{x: POS_W'(P2_X0), y: POS_W'(P2_Y0)};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pos_t          p1_q, p1_d, p2_q, p2_d, out_q, out_d, nxt1, nxt2;
  logic          pn_q, pn_d, se_q, se_d;
  logic [4:0]    res_q, res_d;
  logic [15:0]   sc_q, sc_d;
  logic          exc, tick, hold;
  logic          unused_exc;

  assign exc        = exc_in[EXC_ANY];
  assign tick       = (cnt_q == CNT_LAST);
  assign hold       = (state_q == HALT);
  assign unused_exc = ^exc_in[31:5];

  heading_reg #(.INIT_HEAD(RIGHT), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_head_p1 (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .btn   (btn_p1),
    .pos   (p1_q),
    .nxt   (nxt1)
  );

  heading_reg #(.INIT_HEAD(LEFT), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_head_p2 (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .btn   (btn_p2),
    .pos   (p2_q),
    .nxt   (nxt2)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p1_q    <= P1_INIT;
      p2_q    <= P2_INIT;
      out_q   <= P1_INIT;
      pn_q    <= 1'b0;
      se_q    <= 1'b0;
      res_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      out_q   <= out_d;
      pn_q    <= pn_d;
      se_q    <= se_d;
      res_q   <= res_d;
      sc_q    <= sc_d;
    end
  end

  // An exception outranks every normal transition once play has started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (exc) state_d = HALT; else if (tick) state_d = STEP1;
      STEP1:   state_d = exc ? HALT : STEP2;
      STEP2:   state_d = exc ? HALT : WAIT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    p1_d  = p1_q;
    p2_d  = p2_q;
    out_d = out_q;
    pn_d  = pn_q;
    se_d  = 1'b0;
    res_d = res_q;
    sc_d  = sc_q;

    case (state_q)
      IDLE:        if (start) cnt_d = '0;
      WAIT:        cnt_d = tick ? '0 : cnt_q + CW'(1);
      STEP1, STEP2: cnt_d = cnt_q + CW'(1);
      default:     cnt_d = cnt_q;
    endcase

    // Outputs are registered, so they are loaded on the edge entering a state.
    case (state_d)
      STEP1: begin
        p1_d  = nxt1;
        out_d = nxt1;
        pn_d  = 1'b0;
        se_d  = 1'b1;
      end
      STEP2: begin
        p2_d  = nxt2;
        out_d = nxt2;
        pn_d  = 1'b1;
        se_d  = 1'b1;
      end
      WAIT: begin
        if (state_q == STEP2 && sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
      end
      HALT: begin
        if (state_q != HALT) res_d = exc_in[4:0];
      end
      default: ;
    endcase
  end

  assign play_x       = {{(32-POS_W){1'b0}}, out_q.x};
  assign play_y       = {{(32-POS_W){1'b0}}, out_q.y};
  assign play_num     = pn_q;
  assign super_enable = se_q;
  assign running      = (state_q == WAIT) || (state_q == STEP1) || (state_q == STEP2);
  assign halted       = (state_q == HALT);
  assign result       = res_q;
  assign step_count   = sc_q;

endmodule

// File: tb/tb_player_step_ctrl.sv
// Randomized bench for player_step_ctrl against a tick-index reference model
// (step events derived from cycles-since-start modulo TICK_DIV).
module tb_player_step_ctrl;

  localparam int T  = 4;
  localparam int GW = 64;
  localparam int GH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  btn_p1 = 4'd0;
  logic [3:0]  btn_p2 = 4'd0;
  logic [31:0] exc_in = 32'd0;
  logic [31:0] play_x, play_y;
  logic        play_num, super_enable, running, halted;
  logic [4:0]  result;
  logic [15:0] step_count;

  player_step_ctrl #(.GRID_W(GW), .GRID_H(GH), .TICK_DIV(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .btn_p1       (btn_p1),
    .btn_p2       (btn_p2),
    .exc_in       (exc_in),
    .play_x       (play_x),
    .play_y       (play_y),
    .play_num     (play_num),
    .super_enable (super_enable),
    .running      (running),
    .halted       (halted),
    .result       (result),
    .step_count   (step_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: k counts edges since start was accepted.
  bit m_run, m_halt;
  int k, p1x, p1y, p2x, p2y, h1, h2;
  int m_px, m_py, m_pn, m_se, m_res, m_sc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("play_x", play_x, m_px);
    chk("play_y", play_y, m_py);
    chk("play_num", {31'd0, play_num}, m_pn);
    chk("super_enable", {31'd0, super_enable}, m_se);
    chk("running", {31'd0, running}, {31'd0, m_run});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("result", {27'd0, result}, m_res);
    chk("step_count", {16'd0, step_count}, m_sc);
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; k = 0;
    p1x = 8; p1y = 32; p2x = 55; p2y = 32;
    h1 = 1; h2 = 3;
    m_px = 8; m_py = 32; m_pn = 0; m_se = 0; m_res = 0; m_sc = 0;
  endtask

  function automatic int new_head(input int h, input logic [3:0] b);
    int idx = h;
    if ($countones(b) != 1) return h;
    for (int i = 0; i < 4; i++) if (b[i]) idx = i;
    return (idx == (h ^ 2)) ? h : idx;
  endfunction

  task automatic move(input int h, inout int x, inout int y);
    case (h)
      0: y = (y + GH - 1) % GH;
      1: x = (x + 1) % GW;
      2: y = (y + 1) % GH;
      default: x = (x + GW - 1) % GW;
    endcase
  endtask

  task automatic model_edge();
    bit was_halt = m_halt;
    int oh1 = h1;
    int oh2 = h2;
    if (m_run) begin
      k++;
      m_se = 0;
      if (exc_in[0]) begin
        m_run = 0; m_halt = 1; m_res = int'(exc_in[4:0]);
      end else if (k >= T && k % T == 0) begin
        move(oh1, p1x, p1y); m_px = p1x; m_py = p1y; m_pn = 0; m_se = 1;
      end else if (k >= T + 1 && k % T == 1) begin
        move(oh2, p2x, p2y); m_px = p2x; m_py = p2y; m_pn = 1; m_se = 1;
      end else if (k >= T + 2 && k % T == 2 && m_sc < 65535) begin
        m_sc++;
      end
    end else if (!m_halt && start) begin
      m_run = 1; k = 0;
    end
    if (!was_halt) begin
      h1 = new_head(h1, btn_p1);
      h2 = new_head(h2, btn_p2);
    end
  endtask

  // rst_lvl=0 drops reset between edges and checks the asynchronous effect.
  task automatic cycle(input bit rst_lvl);
    @(negedge clock);
    #2 reset = rst_lvl;
    if (!rst_lvl) begin
      model_reset();
      #1 compare_all();
    end
    @(posedge clock);
    if (reset) model_edge();
    #1 compare_all();
  endtask

  function automatic logic [3:0] rand_btn();
    int r = $urandom_range(0, 9);
    if (r < 6) return 4'(1 << $urandom_range(0, 3));
    if (r < 8) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    model_reset();
    cycle(0);
    cycle(0);

    // Basic step pair and heading rules.
    start = 1'b1; cycle(1); start = 1'b0;
    repeat (6) cycle(1);
    btn_p1 = 4'b1000; repeat (T) cycle(1);
    btn_p1 = 4'b0001; repeat (T) cycle(1);
    btn_p1 = 4'b0011; repeat (T) cycle(1);
    btn_p1 = 4'b0000;

    // Async reset while waiting for a tick.
    for (int i = 0; i < 20 && !(m_run && m_se == 0); i++) cycle(1);
    chk("reach_wait", {31'd0, (m_run && m_se == 0)}, 32'd1);
    cycle(0);
    cycle(1);

    // Wrap: P1 runs right past x=63, P2 runs up past y=0.
    start = 1'b1; cycle(1); start = 1'b0;
    btn_p1 = 4'b0010; btn_p2 = 4'b0001;
    repeat (70 * T) cycle(1);
    btn_p1 = 4'b0000; btn_p2 = 4'b0000;

    // Exception during STEP1 suppresses the P2 step; start ignored in HALT.
    for (int i = 0; i < 20 && !(m_se == 1 && m_pn == 0); i++) cycle(1);
    chk("reach_step1", {31'd0, (m_se == 1 && m_pn == 0)}, 32'd1);
    exc_in = 32'h13; cycle(1); exc_in = 32'd0;
    chk("halt_result", {27'd0, result}, 32'h13);
    start = 1'b1; repeat (6) cycle(1); start = 1'b0;
    cycle(0);
    cycle(1);

    // Async reset during STEP2.
    start = 1'b1; cycle(1); start = 1'b0;
    for (int i = 0; i < 20 && !(m_se == 1 && m_pn == 1); i++) cycle(1);
    chk("reach_step2", {31'd0, (m_se == 1 && m_pn == 1)}, 32'd1);
    cycle(0);
    cycle(1);

    // Random play.
    repeat (3000) begin
      bit rst;
      start  = ($urandom_range(0, 7) == 0);
      btn_p1 = rand_btn();
      btn_p2 = rand_btn();
      exc_in = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 199) == 0) exc_in[0] = 1'b1;
      rst = (m_halt && $urandom_range(0, 9) == 0) || ($urandom_range(0, 299) == 0);
      cycle(!rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
